// File: rtl/gf_mul_pkg.sv
// Shared types and sizing helpers for the digit-serial GF(2^m) multiplier.
package gf_mul_pkg;

    // Control states of the multiplier sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Integer ceiling division, used to size the digit count.
    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Iteration counter width; one spare bit keeps NUM_DIGITS==1 legal.
    function automatic int unsigned cnt_width(input int unsigned num_digits);
        return $clog2(num_digits) + 1;
    endfunction

    // Sizing for the default B-163 configuration with 64-bit digits.
    localparam int unsigned DEF_DATA_WIDTH = 163;
    localparam int unsigned DEF_DIGITAL    = 64;
    localparam int unsigned DEF_NUM_DIGITS = ceil_div(DEF_DATA_WIDTH, DEF_DIGITAL);
    localparam int unsigned DEF_PAD_WIDTH  = DEF_NUM_DIGITS * DEF_DIGITAL;
    localparam int unsigned DEF_CNT_W      = cnt_width(DEF_NUM_DIGITS);

endpackage

// File: rtl/gf_mul_digit_serial_seq_gf_digit_step.sv
// One digit of MSB-first polynomial-basis multiply: DIGITAL chained
// shift / reduce / accumulate cells, most significant digit bit first.
module gf_digit_step
    import gf_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIGITAL    = DEF_DIGITAL
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] g,
    input  logic [DIGITAL-1:0]    d,
    input  logic [DATA_WIDTH-1:0] t_in,
    output logic [DATA_WIDTH-1:0] t_out
);

    logic [DATA_WIDTH-1:0] chain [DIGITAL+1];

    assign chain[0] = t_in;

    // Cell i consumes digit bit DIGITAL-1-i: t' = t*x mod f + bit*a.
    for (genvar i = 0; i < DIGITAL; i++) begin : g_cell
        logic [DATA_WIDTH-1:0] t_shl;
        logic [DATA_WIDTH-1:0] t_red;
        logic [DATA_WIDTH-1:0] t_acc;

        assign t_shl = chain[i] << 1;
        assign t_red = chain[i][DATA_WIDTH-1] ? g : '0;
        assign t_acc = d[DIGITAL-1-i] ? a : '0;
        assign chain[i+1] = t_shl ^ t_red ^ t_acc;
    end

    assign t_out = chain[DIGITAL];

endmodule

// File: rtl/gf_mul_digit_serial_seq.sv
// Sequential digit-serial GF(2^m) multiplier with valid/ready on both sides.
// Operands are captured in IDLE, NUM_DIGITS digit steps run in RUN, and the
// result is held in DONE until the consumer accepts it.
module gf_mul_digit_serial_seq
    import gf_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIGITAL    = DEF_DIGITAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] g,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int unsigned NUM_DIGITS = ceil_div(DATA_WIDTH, DIGITAL);
    localparam int unsigned PAD_WIDTH  = NUM_DIGITS * DIGITAL;
    localparam int unsigned CNT_W      = cnt_width(NUM_DIGITS);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] g_q, g_d;
    logic [PAD_WIDTH-1:0]  shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] t_q, t_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] t_step;
    logic                  last_digit;

    assign last_digit = (cnt_q == '0);

    gf_digit_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIGITAL    (DIGITAL)
    ) u_step (
        .a     (a_q),
        .g     (g_q),
        .d     (shreg_q[PAD_WIDTH-1 -: DIGITAL]),
        .t_in  (t_q),
        .t_out (t_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from registered state only.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next-state: operand capture, digit iteration, result latch.
    always_comb begin
        a_d      = a_q;
        g_d      = g_q;
        shreg_d  = shreg_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    g_d     = g;
                    shreg_d = PAD_WIDTH'(b);
                    t_d     = '0;
                    cnt_d   = CNT_W'(NUM_DIGITS - 1);
                end
            end
            RUN: begin
                t_d     = t_step;
                shreg_d = shreg_q << DIGITAL;
                if (last_digit) begin
                    result_d = t_step;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            g_q      <= '0;
            shreg_q  <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            g_q      <= g_d;
            shreg_q  <= shreg_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_gf_mul_digit_serial_seq.sv
// Bench for gf_mul_digit_serial_seq: five configurations side by side,
// directed vectors plus random operands against a carry-less-multiply model.
module tb_gf_mul_digit_serial_seq;

    localparam int unsigned NI = 5;

    logic            clk;
    logic            rst_n;
    logic [NI-1:0]   iv;
    logic [NI-1:0]   ordy;
    wire  [NI-1:0]   irdy;
    wire  [NI-1:0]   ov;
    wire  [NI-1:0]   bsy;
    logic [162:0]    av [NI];
    logic [162:0]    bv [NI];
    logic [162:0]    gv [NI];
    wire  [3:0]      r0;
    wire  [4:0]      r1;
    wire  [162:0]    r2;
    wire  [7:0]      r3;
    wire  [7:0]      r4;

    // Field width and expected handshake-to-out_valid latency per instance.
    int unsigned dw  [NI] = '{4, 5, 163, 8, 8};
    int          lat [NI] = '{3, 4, 4, 9, 2};

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gf_mul_digit_serial_seq #(.DATA_WIDTH(4), .DIGITAL(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(av[0][3:0]), .b(bv[0][3:0]), .g(gv[0][3:0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .result(r0), .busy(bsy[0]));

    gf_mul_digit_serial_seq #(.DATA_WIDTH(5), .DIGITAL(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(av[1][4:0]), .b(bv[1][4:0]), .g(gv[1][4:0]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .result(r1), .busy(bsy[1]));

    gf_mul_digit_serial_seq #(.DATA_WIDTH(163), .DIGITAL(64)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(av[2]), .b(bv[2]), .g(gv[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .result(r2), .busy(bsy[2]));

    gf_mul_digit_serial_seq #(.DATA_WIDTH(8), .DIGITAL(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]),
        .a(av[3][7:0]), .b(bv[3][7:0]), .g(gv[3][7:0]), .out_valid(ov[3]),
        .out_ready(ordy[3]), .result(r3), .busy(bsy[3]));

    gf_mul_digit_serial_seq #(.DATA_WIDTH(8), .DIGITAL(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(irdy[4]),
        .a(av[4][7:0]), .b(bv[4][7:0]), .g(gv[4][7:0]), .out_valid(ov[4]),
        .out_ready(ordy[4]), .result(r4), .busy(bsy[4]));

    function automatic logic [162:0] res_of(input int idx);
        case (idx)
            0:       return 163'(r0);
            1:       return 163'(r1);
            2:       return r2;
            3:       return 163'(r3);
            default: return 163'(r4);
        endcase
    endfunction

    // Random value of degree < m.
    function automatic logic [162:0] rnd(input int unsigned m);
        logic [162:0] v;
        logic [162:0] msk;
        v   = 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        msk = (m >= 163) ? '1 : ((163'(1) << m) - 163'(1));
        return v & msk;
    endfunction

    // Reference: full carry-less product, then long division by x^m + g.
    function automatic logic [162:0] gf_ref(input logic [162:0] x, input logic [162:0] y,
                                            input logic [162:0] g, input int m);
        logic [325:0] p;
        logic [325:0] poly;
        p = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) p = p ^ (326'(x) << i);
        poly = (326'(1) << m) | 326'(g);
        for (int i = 2 * m - 2; i >= m; i--)
            if (p[i]) p = p ^ (poly << (i - m));
        return p[162:0];
    endfunction

    task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present operands, complete the handshake, then scramble the input ports.
    // Returns at the falling edge of cycle 1 (first RUN cycle).
    task automatic start_op(input int idx, input logic [162:0] x, input logic [162:0] y,
                            input logic [162:0] g);
        int k;
        @(negedge clk);
        av[idx] = x;
        bv[idx] = y;
        gv[idx] = g;
        iv[idx] = 1'b1;
        k = 0;
        while (!irdy[idx] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", 163'(irdy[idx]), 163'(1));
        @(posedge clk);
        @(negedge clk);
        iv[idx] = 1'b0;
        av[idx] = rnd(163);
        bv[idx] = rnd(163);
        gv[idx] = rnd(163);
    endtask

    // Count cycles from cycle 1 until out_valid, bounded.
    task automatic wait_done(input int idx, output int cyc);
        cyc = 1;
        while (!ov[idx] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input int idx, input logic [162:0] x, input logic [162:0] y,
                          input logic [162:0] g, input logic [162:0] exp);
        int cyc;
        start_op(idx, x, y, g);
        check("busy_c1", 163'(bsy[idx]), 163'(1));
        check("in_ready_c1", 163'(irdy[idx]), 163'(0));
        wait_done(idx, cyc);
        check("latency", 163'(cyc), 163'(lat[idx]));
        check("result", res_of(idx), exp);
    endtask

    initial begin
        logic [162:0] x, y, g, hold;
        int cyc;
        int vcount;

        rst_n = 1'b0;
        iv    = '0;
        ordy  = '1;
        for (int i = 0; i < NI; i++) begin
            av[i] = '0;
            bv[i] = '0;
            gv[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_in_ready", 163'(irdy[i]), 163'(1));
            check("rst_out_valid", 163'(ov[i]), 163'(0));
            check("rst_busy", 163'(bsy[i]), 163'(0));
            check("rst_result", res_of(i), 163'(0));
        end

        // Directed vectors.
        run_op(0, 163'h2, 163'h8, 163'h3, 163'h3);
        run_op(1, 163'h10, 163'h10, 163'h05, 163'h0D);
        run_op(2, 163'(1) << 162, 163'h2, 163'hC9, 163'hC9);
        y = rnd(163);
        run_op(2, 163'h1, y, 163'hC9, y);
        run_op(3, 163'h57, 163'h83, 163'h1B, 163'hC1);
        run_op(4, 163'h57, 163'h83, 163'h1B, 163'hC1);

        // Random operands on the default configuration.
        for (int n = 0; n < 1000; n++) begin
            x = rnd(163);
            y = rnd(163);
            g = (n % 2 == 0) ? 163'hC9 : rnd(163);
            run_op(2, x, y, g, gf_ref(x, y, g, 163));
        end

        // Random operands on the narrow configurations.
        for (int idx = 0; idx < NI; idx++) begin
            if (idx == 2) continue;
            for (int n = 0; n < 30; n++) begin
                x = rnd(dw[idx]);
                y = rnd(dw[idx]);
                g = rnd(dw[idx]);
                run_op(idx, x, y, g, gf_ref(x, y, g, int'(dw[idx])));
            end
        end

        // Back-pressure: result held while out_ready is low, new requests ignored.
        ordy[1] = 1'b0;
        start_op(1, 163'h10, 163'h10, 163'h05);
        wait_done(1, cyc);
        check("bp_latency", 163'(cyc), 163'(4));
        check("bp_result0", res_of(1), 163'h0D);
        for (int i = 0; i < 5; i++) begin
            iv[1] = 1'b1;
            av[1] = rnd(5);
            bv[1] = rnd(5);
            @(negedge clk);
            check("bp_out_valid", 163'(ov[1]), 163'(1));
            check("bp_result", res_of(1), 163'h0D);
            check("bp_in_ready", 163'(irdy[1]), 163'(0));
        end
        iv[1]   = 1'b0;
        ordy[1] = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 163'(irdy[1]), 163'(1));
        check("bp_release_out_valid", 163'(ov[1]), 163'(0));
        check("bp_release_result", res_of(1), 163'h0D);
        x = rnd(5);
        y = rnd(5);
        run_op(1, x, y, 163'h05, gf_ref(x, y, 163'h05, 5));

        // Reset during the first RUN cycle aborts the operation.
        run_op(0, 163'h2, 163'h8, 163'h3, 163'h3);
        start_op(0, 163'h5, 163'h7, 163'h3);
        check("abort_busy", 163'(bsy[0]), 163'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 163'(irdy[0]), 163'(1));
        check("abort_out_valid", 163'(ov[0]), 163'(0));
        check("abort_busy_after", 163'(bsy[0]), 163'(0));
        check("abort_result", res_of(0), 163'(0));
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov[0]) vcount++;
        end
        check("abort_no_valid", 163'(vcount), 163'(0));
        hold = res_of(0);
        check("abort_result_hold", hold, 163'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
